hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS datapath. Sits beside the forwarding unit.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types, including the hazard sequencer states.
// Rev 1.0
`default_nettype none
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LDUSE  = 2'd1,
    DWAIT  = 2'd2,
    HALTED = 2'd3
  } hzd_state_t;
endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its all-ones value instead of wrapping.
// Rev 1.0
`default_nettype none
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
// hazard_controller: per-cycle advance/hold/flush control for the 5-stage pipeline latches.
// Rev 1.0
`default_nettype none
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int CNT_W         = 16,
  parameter int LDUSE_BUBBLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_dreq,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             exmem_pcsrc,
  input  logic             exmem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] BUB_INIT = 2'(LDUSE_BUBBLES - 1);

  hzd_state_t state, state_nx;
  logic       saved_lduse, saved_lduse_nx;
  logic [1:0] bub, bub_nx;
  logic       ldhaz;
  logic       flush_inc;
  logic       stall_inc;

  assign ldhaz  = idex_memread && (idex_rt != '0) &&
                  ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  assign halted = (state == HALTED);

  always_comb begin
    state_nx       = state;
    saved_lduse_nx = saved_lduse;
    bub_nx         = bub;
    flush_inc      = 1'b0;
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
    {ifid_flush, idex_flush, exmem_flush}         = 3'b000;
    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
    end else if (state == HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (state == DWAIT) begin
      // Bubble count is untouched while waiting, so LDUSE resumes exactly where it froze.
      if (dhit) begin
        state_nx = saved_lduse ? LDUSE : RUN;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end
    end else if (exmem_dreq && !dhit) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      state_nx       = DWAIT;
      saved_lduse_nx = (state == LDUSE);
    end else if (exmem_halt) begin
      pc_en = 1'b0;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      state_nx = HALTED;
    end else if (exmem_pcsrc) begin
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      flush_inc = 1'b1;
      state_nx  = RUN;
      bub_nx    = 2'd0;
    end else if (state == RUN && ldhaz) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (LDUSE_BUBBLES > 1) begin
        state_nx = LDUSE;
        bub_nx   = BUB_INIT;
      end
    end else if (state == LDUSE) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      bub_nx     = bub - 2'd1;
      if (bub == 2'd1) begin
        state_nx = RUN;
      end
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      saved_lduse <= 1'b0;
      bub         <= 2'd0;
    end else begin
      state       <= state_nx;
      saved_lduse <= saved_lduse_nx;
      bub         <= bub_nx;
    end
  end

  assign stall_inc = !RST && !pc_en && !halted;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven and scoreboard checks of hazard_controller in three configurations.
// Rev 1.0
`default_nettype none
module tb_hazard_controller;
  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       idex_memread, exmem_dreq, dhit, ihit, exmem_pcsrc, exmem_halt;

  // Output vector order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem flushes; halted
  wire [8:0]  oa, ob, oc;
  wire [15:0] sa, fa, sb, fb;
  wire [1:0]  sc, fc;

  always #5 CLK = ~CLK;

  hazard_controller dut_a (
    .CLK(CLK), .RST(RST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_dreq(exmem_dreq),
    .dhit(dhit), .ihit(ihit), .exmem_pcsrc(exmem_pcsrc), .exmem_halt(exmem_halt),
    .pc_en(oa[8]), .ifid_en(oa[7]), .idex_en(oa[6]), .exmem_en(oa[5]), .memwb_en(oa[4]),
    .ifid_flush(oa[3]), .idex_flush(oa[2]), .exmem_flush(oa[1]), .halted(oa[0]),
    .stall_cnt(sa), .flush_cnt(fa)
  );

  hazard_controller #(.LDUSE_BUBBLES(2)) dut_b (
    .CLK(CLK), .RST(RST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_dreq(exmem_dreq),
    .dhit(dhit), .ihit(ihit), .exmem_pcsrc(exmem_pcsrc), .exmem_halt(exmem_halt),
    .pc_en(ob[8]), .ifid_en(ob[7]), .idex_en(ob[6]), .exmem_en(ob[5]), .memwb_en(ob[4]),
    .ifid_flush(ob[3]), .idex_flush(ob[2]), .exmem_flush(ob[1]), .halted(ob[0]),
    .stall_cnt(sb), .flush_cnt(fb)
  );

  hazard_controller #(.CNT_W(2)) dut_c (
    .CLK(CLK), .RST(RST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_dreq(exmem_dreq),
    .dhit(dhit), .ihit(ihit), .exmem_pcsrc(exmem_pcsrc), .exmem_halt(exmem_halt),
    .pc_en(oc[8]), .ifid_en(oc[7]), .idex_en(oc[6]), .exmem_en(oc[5]), .memwb_en(oc[4]),
    .ifid_flush(oc[3]), .idex_flush(oc[2]), .exmem_flush(oc[1]), .halted(oc[0]),
    .stall_cnt(sc), .flush_cnt(fc)
  );

  localparam logic [8:0] ALLEN  = 9'b11111_000_0;
  localparam logic [8:0] FREEZE = 9'b00000_000_0;
  localparam logic [8:0] LDST   = 9'b00111_010_0;
  localparam logic [8:0] IMISS  = 9'b01111_100_0;
  localparam logic [8:0] PCSRC  = 9'b11111_111_0;
  localparam logic [8:0] HALTE  = 9'b00001_111_0;
  localparam logic [8:0] HLTD   = 9'b00000_000_1;
  localparam logic [8:0] RSTO   = 9'b00000_111_0;
  localparam logic [8:0] FULL   = 9'h1FF;
  localparam logic [8:0] NOH    = 9'h1FE;
  localparam logic [8:0] HMASK  = 9'b10001_111_1;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, xrt;
    logic       mr, dreq, dh, ih, pc, ht;
    logic [8:0] exp, mask;
    int         es, ef;
  } vec_t;

  typedef struct {
    int         sel;
    string      tag;
    logic [8:0] exp, mask;
    int         es, ef;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic [4:0] xrt,
                              logic mr, logic dreq, logic dh, logic ih, logic pc, logic ht,
                              logic [8:0] exp, logic [8:0] mask, int es, int ef);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.xrt = xrt; v.mr = mr; v.dreq = dreq;
    v.dh = dh; v.ih = ih; v.pc = pc; v.ht = ht;
    v.exp = exp; v.mask = mask; v.es = es; v.ef = ef;
    return v;
  endfunction

  task automatic drive(input vec_t v, input int sel, input string tag);
    exp_t e;
    RST = v.rst; ifid_rs = v.rs; ifid_rt = v.rt; idex_rt = v.xrt; idex_memread = v.mr;
    exmem_dreq = v.dreq; dhit = v.dh; ihit = v.ih; exmem_pcsrc = v.pc; exmem_halt = v.ht;
    e.sel = sel; e.tag = tag; e.exp = v.exp; e.mask = v.mask; e.es = v.es; e.ef = v.ef;
    sbq.push_back(e);
  endtask

  task automatic check_front();
    exp_t       e;
    logic [8:0] act;
    int         act_s, act_f;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue, required an entry");
      return;
    end
    e = sbq.pop_front();
    case (e.sel)
      0:       begin act = oa; act_s = int'(sa); act_f = int'(fa); end
      1:       begin act = ob; act_s = int'(sb); act_f = int'(fb); end
      default: begin act = oc; act_s = int'(sc); act_f = int'(fc); end
    endcase
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      errors++;
      $display("FAIL %s outs: got %b required %b (mask %b)", e.tag, act, e.exp, e.mask);
    end
    if (e.es >= 0) begin
      checks++;
      if (act_s != e.es) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d required %0d", e.tag, act_s, e.es);
      end
    end
    if (e.ef >= 0) begin
      checks++;
      if (act_f != e.ef) begin
        errors++;
        $display("FAIL %s flush_cnt: got %0d required %0d", e.tag, act_f, e.ef);
      end
    end
  endtask

  task automatic step(input vec_t v, input int sel, input string tag);
    drive(v, sel, tag);
    @(negedge CLK);
    check_front();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //           r rs rt xrt mr dq dh ih pc ht  exp     mask   es  ef
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO,   NOH,  -1, -1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO,   FULL,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  0,  0));
    tbl.push_back(mk(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, LDST,   FULL,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  1,  0));
    tbl.push_back(mk(0, 3, 7, 7, 1, 0, 0, 1, 0, 0, LDST,   FULL,  1,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  2,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, ALLEN,  FULL,  2,  0));
    tbl.push_back(mk(0, 5, 0, 5, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  2,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMISS,  FULL,  2,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  3,  0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, FREEZE, FULL, 3 + i, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, ALLEN,  FULL,  7,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  7,  0));
    tbl.push_back(mk(0, 5, 0, 5, 1, 0, 0, 1, 1, 0, PCSRC,  FULL,  7,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  7,  1));
    tbl.push_back(mk(0, 5, 0, 5, 1, 1, 0, 1, 0, 0, FREEZE, FULL,  7,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, ALLEN,  FULL,  8,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  8,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, HALTE,  HMASK, 8,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HLTD,   FULL,  9,  1));
    tbl.push_back(mk(0, 5, 0, 5, 1, 0, 0, 1, 1, 0, HLTD,   FULL,  9,  1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO,   NOH,  -1, -1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  0,  0));
    tbl.push_back(mk(0, 5, 0, 5, 1, 0, 0, 0, 0, 0, LDST,   FULL,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  1,  0));

    foreach (tbl[i]) step(tbl[i], 0, $sformatf("vec%0d", i));

    // Reset while frozen on a dcache miss leaves no residual stall
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, FREEZE, FULL, -1, -1), 0, "a_dwait");
    step(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, RSTO,   NOH,  -1, -1), 0, "a_dwait_rst");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  0,  0), 0, "a_after_rst");

    // Two-bubble configuration
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO,   NOH,  -1, -1), 1, "b_rst");
    step(mk(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, LDST,   FULL,  0,  0), 1, "b_bub1");
    step(mk(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, LDST,   FULL,  1,  0), 1, "b_bub2");
    step(mk(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  2,  0), 1, "b_run");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  2,  0), 1, "b_run2");
    step(mk(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, LDST,   FULL,  2,  0), 1, "b_mid_ld");
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO,   NOH,  -1, -1), 1, "b_mid_rst");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  0,  0), 1, "b_no_resid");
    step(mk(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, LDST,   FULL,  0,  0), 1, "b_ld_a");
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, FREEZE, FULL,  1,  0), 1, "b_ld_freeze");
    step(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, ALLEN,  FULL,  2,  0), 1, "b_ld_release");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, LDST,   FULL,  2,  0), 1, "b_ld_resume");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN,  FULL,  3,  0), 1, "b_ld_done");

    // Two-bit counters saturate
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO,   NOH,  -1, -1), 2, "c_rst");
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, LDST,  FULL, (i > 3) ? 3 : i, 0), 2,
           $sformatf("c_ld%0d", i));
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ALLEN, FULL, (i + 1 > 3) ? 3 : i + 1, 0), 2,
           $sformatf("c_idle%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
